// File: rtl/nios_sys_nios2_qsys_0_jtag_ocimem_ctrl.sv
// ---------------------------------------------------------------------------
// nios_sys_nios2_qsys_0_jtag_ocimem_ctrl
//
// Purpose:
//   System-clock-domain side of the JTAG debug OCI memory path. Decoded
//   command strobes from the JTAG debug module (set address, write word,
//   read next word) become single-word master transfers on the debug-memory
//   bus. The word address auto-increments after every transfer. The last
//   written or read word is returned on MonDReg for the host to shift out.
//
// Handshake:
//   A request (avm_read or avm_write) stays asserted, with address and data
//   held stable, for every cycle that avm_waitrequest is 1. The transfer
//   completes on the first cycle in which the request is high and
//   avm_waitrequest is 0. For reads, avm_readdata is captured in that same
//   cycle.
//
// Ports:
//   clk, reset_n            system clock, synchronous active-low reset
//   jdo                     38-bit command payload, valid with a strobe
//   take_action_ocimem_a    set-address strobe (jdo[34] = read-after-set)
//   take_action_ocimem_b    write-word strobe (data in jdo[34:3])
//   take_no_action_ocimem_a read-next-word strobe
//   avm_*                   debug-memory master port
//   MonAReg / MonDReg       current word address / last data word
//   ocimem_busy             high whenever the controller is not idle
//   cmd_overrun             sticky: a strobe was dropped while busy
// ---------------------------------------------------------------------------
module nios_sys_nios2_qsys_0_jtag_ocimem_ctrl #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    output logic              avm_write,
    output logic [31:0]       avm_writedata,
    input  logic [31:0]       avm_readdata,
    input  logic              avm_waitrequest,
    output logic [31:0]       MonDReg,
    output logic [ADDR_W-1:0] MonAReg,
    output logic              ocimem_busy,
    output logic              cmd_overrun
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2
    } state_t;

    state_t state;

    // Payload bits that carry no meaning for these commands.
    logic unused_jdo_bits;
    assign unused_jdo_bits = ^{jdo[37:35], jdo[2:0]};

    logic any_strobe;
    assign any_strobe = take_action_ocimem_a | take_action_ocimem_b |
                        take_no_action_ocimem_a;

    // The bus address is always the monitor address register.
    assign avm_address = MonAReg;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            MonAReg       <= '0;
            MonDReg       <= '0;
            avm_writedata <= '0;
            avm_read      <= 1'b0;
            avm_write     <= 1'b0;
            ocimem_busy   <= 1'b0;
            cmd_overrun   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // Priority: set-address > write-word > read-next.
                    // Losing strobes in the same cycle are simply ignored.
                    if (take_action_ocimem_a) begin
                        MonAReg     <= jdo[ADDR_W+16:17];
                        cmd_overrun <= 1'b0;
                        if (jdo[34]) begin
                            state       <= ST_RD;
                            avm_read    <= 1'b1;
                            ocimem_busy <= 1'b1;
                        end
                    end else if (take_action_ocimem_b) begin
                        MonDReg       <= jdo[34:3];
                        avm_writedata <= jdo[34:3];
                        state         <= ST_WR;
                        avm_write     <= 1'b1;
                        ocimem_busy   <= 1'b1;
                    end else if (take_no_action_ocimem_a) begin
                        state       <= ST_RD;
                        avm_read    <= 1'b1;
                        ocimem_busy <= 1'b1;
                    end
                end

                ST_RD: begin
                    if (any_strobe) begin
                        cmd_overrun <= 1'b1;
                    end
                    if (!avm_waitrequest) begin
                        MonDReg     <= avm_readdata;
                        MonAReg     <= MonAReg + ADDR_W'(1);
                        state       <= ST_IDLE;
                        avm_read    <= 1'b0;
                        ocimem_busy <= 1'b0;
                    end
                end

                ST_WR: begin
                    if (any_strobe) begin
                        cmd_overrun <= 1'b1;
                    end
                    if (!avm_waitrequest) begin
                        MonAReg     <= MonAReg + ADDR_W'(1);
                        state       <= ST_IDLE;
                        avm_write   <= 1'b0;
                        ocimem_busy <= 1'b0;
                    end
                end

                default: begin
                    state       <= ST_IDLE;
                    avm_read    <= 1'b0;
                    avm_write   <= 1'b0;
                    ocimem_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nios_sys_nios2_qsys_0_jtag_ocimem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_nios_sys_nios2_qsys_0_jtag_ocimem_ctrl
//
// Directed bench for the OCI memory controller. Inputs are driven 1 ns after
// each rising edge and outputs are sampled at the same point, so every
// sample reflects the registers updated by the edge just passed.
// ---------------------------------------------------------------------------
module tb_nios_sys_nios2_qsys_0_jtag_ocimem_ctrl;

    localparam int ADDR_W = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset_n;
    logic [37:0]       jdo;
    logic              take_action_ocimem_a;
    logic              take_action_ocimem_b;
    logic              take_no_action_ocimem_a;
    logic [ADDR_W-1:0] avm_address;
    logic              avm_read;
    logic              avm_write;
    logic [31:0]       avm_writedata;
    logic [31:0]       avm_readdata;
    logic              avm_waitrequest;
    logic [31:0]       MonDReg;
    logic [ADDR_W-1:0] MonAReg;
    logic              ocimem_busy;
    logic              cmd_overrun;

    nios_sys_nios2_qsys_0_jtag_ocimem_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .avm_address             (avm_address),
        .avm_read                (avm_read),
        .avm_write               (avm_write),
        .avm_writedata           (avm_writedata),
        .avm_readdata            (avm_readdata),
        .avm_waitrequest         (avm_waitrequest),
        .MonDReg                 (MonDReg),
        .MonAReg                 (MonAReg),
        .ocimem_busy             (ocimem_busy),
        .cmd_overrun             (cmd_overrun)
    );

    // ---------------- scoreboard counters ----------------
    int n_compared   = 0;
    int n_mismatched = 0;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        n_compared++;
        assert (observed === expected) else begin
            n_mismatched++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobes(input logic a, input logic b, input logic n);
        take_action_ocimem_a    = a;
        take_action_ocimem_b    = b;
        take_no_action_ocimem_a = n;
    endtask

    function automatic logic [37:0] jdo_addr(input logic [ADDR_W-1:0] addr,
                                             input logic rd);
        logic [37:0] v;
        v = '0;
        v[ADDR_W+16:17] = addr;
        v[34] = rd;
        return v;
    endfunction

    function automatic logic [37:0] jdo_data(input logic [31:0] d);
        logic [37:0] v;
        v = '0;
        v[34:3] = d;
        return v;
    endfunction

    // ---------------- directed stimulus ----------------
    initial begin
        reset_n         = 1'b0;
        jdo             = '0;
        avm_readdata    = '0;
        avm_waitrequest = 1'b0;
        strobes(1'b0, 1'b0, 1'b0);

        // Reset with random strobes: everything must stay at zero.
        for (int i = 0; i < 3; i++) begin
            jdo = {6'($urandom_range(0, 63)), 32'($urandom)};
            strobes(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            tick();
            check("rst_read",   avm_read,      0);
            check("rst_write",  avm_write,     0);
            check("rst_busy",   ocimem_busy,   0);
            check("rst_ovr",    cmd_overrun,   0);
            check("rst_monA",   MonAReg,       0);
            check("rst_monD",   MonDReg,       0);
            check("rst_wdata",  avm_writedata, 0);
        end
        strobes(1'b0, 1'b0, 1'b0);
        reset_n = 1'b1;
        tick();
        check("idle_read",  avm_read,  0);
        check("idle_write", avm_write, 0);

        // Set address 0x10 without read, then write 0xDEADBEEF.
        jdo = jdo_addr(8'h10, 1'b0);
        strobes(1'b1, 1'b0, 1'b0);
        tick();
        strobes(1'b0, 1'b0, 1'b0);
        check("seta_monA", MonAReg,     32'h10);
        check("seta_read", avm_read,    0);
        check("seta_busy", ocimem_busy, 0);

        jdo = jdo_data(32'hDEADBEEF);
        strobes(1'b0, 1'b1, 1'b0);
        tick();
        strobes(1'b0, 1'b0, 1'b0);
        check("wr_write", avm_write,     1);
        check("wr_addr",  avm_address,   32'h10);
        check("wr_data",  avm_writedata, 32'hDEADBEEF);
        check("wr_monD",  MonDReg,       32'hDEADBEEF);
        check("wr_busy",  ocimem_busy,   1);
        tick();
        check("wr_done_write", avm_write,   0);
        check("wr_done_monA",  MonAReg,     32'h11);
        check("wr_done_busy",  ocimem_busy, 0);

        // Set address 0x20 with read flag, three wait states.
        jdo = jdo_addr(8'h20, 1'b1);
        avm_waitrequest = 1'b1;
        strobes(1'b1, 1'b0, 1'b0);
        tick();
        strobes(1'b0, 1'b0, 1'b0);
        check("rdw_read1", avm_read,    1);
        check("rdw_addr1", avm_address, 32'h20);
        tick();
        check("rdw_read2", avm_read,    1);
        tick();
        check("rdw_read3", avm_read,    1);
        check("rdw_addr3", avm_address, 32'h20);
        tick();
        check("rdw_read4", avm_read,    1);
        avm_waitrequest = 1'b0;
        avm_readdata    = 32'h12345678;
        tick();
        check("rdw_done_read", avm_read, 0);
        check("rdw_monD",      MonDReg,  32'h12345678);
        check("rdw_monA",      MonAReg,  32'h21);

        // Wrap-around: 0xFF then 0x00.
        jdo = jdo_addr(8'hFF, 1'b0);
        strobes(1'b1, 1'b0, 1'b0);
        tick();
        strobes(1'b0, 1'b0, 1'b1);
        tick();
        strobes(1'b0, 1'b0, 1'b0);
        check("wrap_read1", avm_read,    1);
        check("wrap_addr1", avm_address, 32'hFF);
        avm_readdata = 32'h0000A5A5;
        tick();
        check("wrap_monA1", MonAReg, 32'h00);
        check("wrap_monD1", MonDReg, 32'h0000A5A5);
        // Back-to-back: strobe in the first idle cycle is accepted.
        strobes(1'b0, 1'b0, 1'b1);
        tick();
        strobes(1'b0, 1'b0, 1'b0);
        check("wrap_read2", avm_read,    1);
        check("wrap_addr2", avm_address, 32'h00);
        avm_readdata = 32'h00005A5A;
        tick();
        check("wrap_monA2", MonAReg, 32'h01);
        check("wrap_monD2", MonDReg, 32'h00005A5A);

        // Priority: set-address beats write and read in the same cycle.
        jdo = jdo_addr(8'h40, 1'b0);
        strobes(1'b1, 1'b1, 1'b1);
        tick();
        strobes(1'b0, 1'b0, 1'b0);
        check("prio_monA",  MonAReg,   32'h40);
        check("prio_write", avm_write, 0);
        check("prio_read",  avm_read,  0);
        check("prio_ovr",   cmd_overrun, 0);

        // Overrun: strobes during a stalled write are dropped.
        jdo = jdo_data(32'hCAFEF00D);
        avm_waitrequest = 1'b1;
        strobes(1'b0, 1'b1, 1'b0);
        tick();
        check("ovr_write", avm_write, 1);
        strobes(1'b0, 1'b0, 1'b1);
        tick();
        check("ovr_flag",  cmd_overrun, 1);
        check("ovr_write2", avm_write,  1);
        jdo = jdo_addr(8'h77, 1'b1);
        strobes(1'b1, 1'b0, 1'b0);
        tick();
        strobes(1'b0, 1'b0, 1'b0);
        check("ovr_monA_hold", MonAReg,       32'h40);
        check("ovr_wdata",     avm_writedata, 32'hCAFEF00D);
        avm_waitrequest = 1'b0;
        tick();
        check("ovr_wdone_write", avm_write,   0);
        check("ovr_wdone_monA",  MonAReg,     32'h41);
        check("ovr_sticky",      cmd_overrun, 1);
        tick();
        check("ovr_no_read", avm_read, 0);
        jdo = jdo_addr(8'h50, 1'b0);
        strobes(1'b1, 1'b0, 1'b0);
        tick();
        strobes(1'b0, 1'b0, 1'b0);
        check("ovr_clear", cmd_overrun, 0);
        check("ovr_monA",  MonAReg,     32'h50);

        // Reset during a stalled read.
        avm_waitrequest = 1'b1;
        strobes(1'b0, 1'b0, 1'b1);
        tick();
        strobes(1'b0, 1'b0, 1'b0);
        check("mrst_read_on", avm_read, 1);
        reset_n = 1'b0;
        tick();
        check("mrst_read", avm_read,    0);
        check("mrst_busy", ocimem_busy, 0);
        check("mrst_monD", MonDReg,     0);
        check("mrst_monA", MonAReg,     0);
        reset_n = 1'b1;
        avm_waitrequest = 1'b0;
        tick();
        tick();
        check("mrst_no_retry", avm_read,    0);
        check("mrst_idle",     ocimem_busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
